// File: rtl/inv_mixcolumns_stage.sv
// inv_mixcolumns_stage: two-stage pipelined AES InvMixColumns with final-round bypass and valid/ready flow control
module inv_mixcolumns_stage #(
   parameter int DATA_W    = 128,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   logic              s1_valid, s2_valid, s1_last, s2_last;
   logic              s1_load, s2_load;
   logic [DATA_W-1:0] s1_x1, s1_x2, s1_x4, s1_x8, s2_data;
   logic [DATA_W-1:0] x2_d, x4_d, x8_d, mix_d;
   assign s2_load   = out_ready | ~s2_valid;
   assign s1_load   = s2_load | ~s1_valid;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid;
   assign out_data  = s2_data;
   assign out_last  = s2_last;
   assign busy      = s1_valid | s2_valid;
   for (genvar b = 0; b < 16; b++) begin : g_xt
      assign x2_d[8*b +: 8] = xtime(in_data[8*b +: 8]);
      assign x4_d[8*b +: 8] = xtime(x2_d[8*b +: 8]);
      assign x8_d[8*b +: 8] = xtime(x4_d[8*b +: 8]);
   end
   // row r of each column takes 0e,0b,0d,09 times rows r, r+1, r+2, r+3 (mod 4)
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int P0 = 127 - 32*c - 8*r;
         localparam int P1 = 127 - 32*c - 8*((r+1)%4);
         localparam int P2 = 127 - 32*c - 8*((r+2)%4);
         localparam int P3 = 127 - 32*c - 8*((r+3)%4);
         assign mix_d[P0 -: 8] = (s1_x8[P0 -: 8] ^ s1_x4[P0 -: 8] ^ s1_x2[P0 -: 8])
                               ^ (s1_x8[P1 -: 8] ^ s1_x2[P1 -: 8] ^ s1_x1[P1 -: 8])
                               ^ (s1_x8[P2 -: 8] ^ s1_x4[P2 -: 8] ^ s1_x1[P2 -: 8])
                               ^ (s1_x8[P3 -: 8] ^ s1_x1[P3 -: 8]);
      end
   end
   // stage 1: capture per-byte multiples of the accepted state
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_x1    <= '0;
         s1_x2    <= '0;
         s1_x4    <= '0;
         s1_x8    <= '0;
      end else begin
         if (s1_load) s1_valid <= in_valid;
         if (s1_load && in_valid) begin
            s1_last <= in_last;
            s1_x1   <= in_data;
            s1_x2   <= x2_d;
            s1_x4   <= x4_d;
            s1_x8   <= x8_d;
         end
      end
   end
   // stage 2: combine multiples into the column result, or pass the state through on a bypassed last round
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_data  <= '0;
      end else begin
         if (s2_load) s2_valid <= s1_valid;
         if (s2_load && s1_valid) begin
            s2_last <= s1_last;
            s2_data <= (BYPASS_EN && s1_last) ? s1_x1 : mix_d;
         end
      end
   end
endmodule

// File: tb/tb_inv_mixcolumns_stage.sv
// tb_inv_mixcolumns_stage: randomized scoreboard bench for the InvMixColumns pipeline stage
module tb_inv_mixcolumns_stage;
   localparam logic [127:0] VEC   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] VMIX  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] MTX   = 128'h0e0b0d09_090e0b0d_0d090e0b_0b0d090e;
   logic         clk = 1'b0, rst, in_valid, in_last, out_ready;
   logic [127:0] in_data;
   logic         in_ready, out_valid, out_last, busy;
   logic [127:0] out_data;
   logic         in_ready_nb, out_valid_nb, out_last_nb, busy_nb;
   logic [127:0] out_data_nb;
   int           n_checks = 0, n_fail = 0;
   logic [128:0] exp_q[$];
   logic [128:0] nb_q[$];
   always #5 clk = ~clk;
   inv_mixcolumns_stage #(.DATA_W(128), .BYPASS_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy));
   inv_mixcolumns_stage #(.DATA_W(128), .BYPASS_EN(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nb), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid_nb), .out_ready(out_ready), .out_data(out_data_nb),
      .out_last(out_last_nb), .busy(busy_nb));
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction
   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o = '0;
      logic [7:0]   acc;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(MTX[127-32*r-8*j -: 8], s[127-32*c-8*j -: 8]);
            o[127-32*c-8*r -: 8] = acc;
         end
      return o;
   endfunction
   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic cycle(input logic v, input logic [127:0] d, input logic l, input logic ordy);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
      #1;
   endtask
   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      rst = 1'b1;
   endtask
   task automatic test_single();
      cycle(1'b1, VEC, 1'b0, 1'b1);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
      cycle(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_latency1: out_valid %b busy %b expected 0 1", out_valid, busy); end
      cycle(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency2: out_valid %b expected 1", out_valid); end
      n_checks++; if (out_data !== VMIX || out_last !== 1'b0) begin n_fail++; $display("FAIL single_data: got %h/%b expected %h/0", out_data, out_last, VMIX); end
      n_checks++; if (out_data_nb !== VMIX) begin n_fail++; $display("FAIL single_data_nb: got %h expected %h", out_data_nb, VMIX); end
      cycle(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_drain: out_valid %b busy %b expected 0 0", out_valid, busy); end
   endtask
   task automatic test_bypass();
      cycle(1'b1, VEC, 1'b1, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b1 || out_data !== VEC || out_last !== 1'b1) begin n_fail++; $display("FAIL bypass_data: valid %b got %h/%b expected %h/1", out_valid, out_data, out_last, VEC); end
      n_checks++; if (out_valid_nb !== 1'b1 || out_data_nb !== VMIX || out_last_nb !== 1'b1) begin n_fail++; $display("FAIL bypass_disabled: valid %b got %h/%b expected %h/1", out_valid_nb, out_data_nb, out_last_nb, VMIX); end
      cycle(1'b0, '0, 1'b0, 1'b1);
   endtask
   task automatic test_streaming();
      int got = 0;
      logic [127:0] d;
      logic [128:0] e;
      exp_q.delete();
      for (int i = 0; i < 12; i++) begin
         d = rand128();
         cycle(i < 8, d, 1'b0, 1'b1);
         if (i < 8) begin n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready: cycle %0d got %b expected 1", i, in_ready); end end
         if (i >= 2 && i < 10) begin n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_gap: cycle %0d out_valid %b expected 1", i, out_valid); end end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_extra: unexpected output %h", out_data); end
            else begin
               e = exp_q.pop_front();
               if ({out_last, out_data} !== e) begin n_fail++; $display("FAIL stream_data: got %h expected %h", {out_last, out_data}, e); end
            end
            got++;
         end
         if (in_valid && in_ready) exp_q.push_back({1'b0, inv_mix(d)});
      end
      n_checks++; if (got != 8) begin n_fail++; $display("FAIL stream_count: got %0d expected 8", got); end
   endtask
   task automatic test_backpressure();
      int acc = 0, got = 0;
      logic [127:0] d;
      logic [128:0] e, hold = '0;
      exp_q.delete();
      for (int k = 0; k < 5; k++) begin
         d = rand128();
         cycle(acc < 3, d, 1'b0, 1'b0);
         if (k >= 2) begin n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", k, in_ready); end end
         if (k == 2) hold = {out_last, out_data};
         if (k >= 2) begin n_checks++; if (out_valid !== 1'b1 || {out_last, out_data} !== hold) begin n_fail++; $display("FAIL bp_stable: valid %b got %h expected %h", out_valid, {out_last, out_data}, hold); end end
         if (in_valid && in_ready) begin exp_q.push_back({1'b0, inv_mix(d)}); acc++; end
      end
      n_checks++; if (acc != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 2", acc); end
      for (int k = 0; k < 20 && got < 3; k++) begin
         d = rand128();
         cycle(acc < 3, d, 1'b0, 1'b1);
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: unexpected output %h", out_data); end
            else begin
               e = exp_q.pop_front();
               if ({out_last, out_data} !== e) begin n_fail++; $display("FAIL bp_data: got %h expected %h", {out_last, out_data}, e); end
            end
            got++;
         end
         if (in_valid && in_ready) begin exp_q.push_back({1'b0, inv_mix(d)}); acc++; end
      end
      n_checks++; if (got != 3 || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_count: got %0d left %0d expected 3 0", got, exp_q.size()); end
      cycle(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_dup: out_valid %b busy %b expected 0 0", out_valid, busy); end
   endtask
   task automatic test_reset_midflight();
      logic seen = 1'b0;
      cycle(1'b1, rand128(), 1'b0, 1'b0);
      cycle(1'b1, rand128(), 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: out_valid %b busy %b expected 0 0", out_valid, busy); end
      n_checks++; if (out_data !== 128'h0 || out_last !== 1'b0) begin n_fail++; $display("FAIL rstmid_data: got %h/%b expected 0/0", out_data, out_last); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
      for (int k = 0; k < 6; k++) begin
         cycle(1'b0, '0, 1'b0, 1'b1);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      n_checks++; if (seen) begin n_fail++; $display("FAIL rstmid_stale: stale output %b expected none", seen); end
      exp_q.delete();
   endtask
   task automatic test_random();
      int sent = 0, got = 0, cyc = 0;
      logic v, l, r, prev_hold = 1'b0;
      logic [127:0] d;
      logic [128:0] e, en, prev = '0;
      exp_q.delete();
      nb_q.delete();
      while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
         d = rand128();
         l = 1'($urandom_range(0, 1));
         v = (sent < 1000) && ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         cycle(v, d, l, r);
         cyc++;
         if (prev_hold) begin n_checks++; if (out_valid !== 1'b1 || {out_last, out_data} !== prev) begin n_fail++; $display("FAIL rand_stall: valid %b got %h expected %h", out_valid, {out_last, out_data}, prev); end end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra: unexpected output %h", out_data); end
            else begin
               e = exp_q.pop_front();
               en = nb_q.pop_front();
               if ({out_last, out_data} !== e) begin n_fail++; $display("FAIL rand_data: got %h expected %h", {out_last, out_data}, e); end
               else if (out_valid_nb !== 1'b1 || {out_last_nb, out_data_nb} !== en) begin n_fail++; $display("FAIL rand_data_nb: got %h expected %h", {out_last_nb, out_data_nb}, en); end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({l, l ? d : inv_mix(d)});
            nb_q.push_back({l, inv_mix(d)});
            sent++;
         end
         prev_hold = out_valid && !out_ready;
         prev = {out_last, out_data};
      end
      n_checks++; if (sent != 1000 || got != 1000 || exp_q.size() != 0) begin n_fail++; $display("FAIL rand_complete: sent %0d got %0d left %0d expected 1000 1000 0", sent, got, exp_q.size()); end
   endtask
   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_bypass();
      test_streaming();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
